median_delay_line: RTL

//  Parametrised delay line for the median-filter pixel pipeline. Delays an
//  N-bit sample stream by a runtime-selectable number of clock-enabled cycles
//  (1..DEPTH) and flags when the output holds real data. It replaces chains of

---
 rtl/median_delay_line.sv | 102 ++++++++++
 1 files changed

// File: rtl/median_delay_line.sv
// median_delay_line
//   Runtime-adjustable delay line for the median-filter pixel pipeline.
//   Delays an N-bit sample stream by L clock-enabled cycles (L = clamp(len),
//   1..DEPTH). It also flags when the output holds real data. Storage is a
//   circular buffer of L-1 stages followed by the output register q.
//
// Ports
//   clk      rising-edge clock
//   rst_n    synchronous reset, active low
//   ce       clock enable, one sample accepted per enabled cycle
//   len      requested delay in ce-cycles (0 -> 1, >DEPTH -> DEPTH)
//   d        input sample
//   q        delayed sample (registered, 0 until valid)
//   q_valid  q holds a genuine delayed sample
module median_delay_line #(
    parameter int N     = 5,
    parameter int DEPTH = 16,
    localparam int LEN_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [LEN_W-1:0] len,
    input  logic [N-1:0]     d,
    output logic [N-1:0]     q,
    output logic             q_valid
);

    // The buffer holds at most DEPTH-1 stages. It is rounded up to a power of two
    // so that the pointer indexes it exactly.
    localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;
    localparam int MEM_D = 1 << PTR_W;

    logic [N-1:0]     mem [MEM_D];
    logic [LEN_W-1:0] len_c;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] fill;
    logic [LEN_W-1:0] last_ptr;
    logic [LEN_W:0]   fill_inc;
    logic [PTR_W-1:0] ptr;
    logic             restart;
    logic             accept;
    logic             now_valid;
    logic             wrap;
    logic             bypass;

    // Clamp the requested length. Also derive the per-edge control terms.
    // A change of clamp class causes a restart. The sample presented on that
    // edge is dropped. A length of one bypasses the buffer entirely.
    always_comb begin
        len_c = len;
        if (len == '0) begin
            len_c = LEN_W'(1);
        end else if (len > LEN_W'(DEPTH)) begin
            len_c = LEN_W'(DEPTH);
        end
        restart   = (len_c != len_q);
        accept    = ce && !restart;
        fill_inc  = {1'b0, fill} + (LEN_W + 1)'(1);
        now_valid = (fill_inc >= {1'b0, len_q});
        bypass    = (len_q == LEN_W'(1));
        last_ptr  = len_q - LEN_W'(2);
        wrap      = (LEN_W'(ptr) == last_ptr);
    end

    // Buffer write. The stage under the pointer is read into q on the same
    // edge, so each stage holds a sample for exactly L-1 accepts.
    // The buffer is never cleared. The fill count masks stale contents.
    always_ff @(posedge clk) begin
        if (rst_n && accept && !bypass) begin
            mem[ptr] <= d;
        end
    end

    // Control and output register. q acts as the synchronous read register
    // of the buffer. It is forced to zero until L samples have been accepted.
    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            q       <= '0;
            q_valid <= 1'b0;
            ptr     <= '0;
            fill    <= '0;
            len_q   <= len_c;
        end else if (ce) begin
            if (fill != len_q) begin
                fill <= fill_inc[LEN_W-1:0];
            end
            q_valid <= now_valid;
            if (!now_valid) begin
                q <= '0;
            end else if (bypass) begin
                q <= d;
            end else begin
                q <= mem[ptr];
            end
            if (!bypass) begin
                ptr <= wrap ? '0 : ptr + PTR_W'(1);
            end
        end
    end

endmodule
